wm_cycle_scheduler: RTL and testbench

//  Sequences one automatic wash programme: fill, soap wash, drain, N rinse passes, spin, done.

---
 rtl/wm_cycle_scheduler.sv | 162 ++++++++++++++++
 tb/tb_wm_cycle_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wm_cycle_scheduler.sv
// Washing-machine programme sequencer: fill, soap wash, drain, rinse passes, spin, done.
// Optional pause support is compiled in with `define WM_PAUSE_EN.
module wm_cycle_scheduler #(
   parameter int CNT_W        = 8,
   parameter int WASH_TICKS   = 20,
   parameter int RINSE_TICKS  = 10,
   parameter int SPIN_TICKS   = 15,
   parameter int FILL_TICKS   = 50,
   parameter int RINSE_PASSES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       door_close,
   input  logic       filled,
   input  logic       detergent_added,
   input  logic       drained,
   input  logic       abort,
   input  logic       pause,
   output logic       door_lock,
   output logic       motor_on,
   output logic       fill_valve_on,
   output logic       drain_valve_on,
   output logic       soap_wash,
   output logic       water_wash,
   output logic       done,
   output logic       fault,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FILL      = 4'd1,
      ST_WAIT_SOAP = 4'd2,
      ST_WASH      = 4'd3,
      ST_DRAIN     = 4'd4,
      ST_RINSE     = 4'd5,
      ST_SPIN      = 4'd6,
      ST_DONE      = 4'd7,
      ST_ABORT     = 4'd8,
      ST_FAULT     = 4'd9
   } state_t;

   localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
   localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
   localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [2:0]       PASSES     = 3'(RINSE_PASSES);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [2:0]       pass_reg, pass_next;
   logic             drained_seen_reg, drained_seen_next;
   logic             locked_run;
   logic             timed_stage;
   logic             hold;

   assign locked_run  = (state_reg == ST_FILL) || (state_reg == ST_WAIT_SOAP) ||
                        (state_reg == ST_WASH) || (state_reg == ST_DRAIN) ||
                        (state_reg == ST_RINSE) || (state_reg == ST_SPIN);
   assign timed_stage = (state_reg == ST_WASH) || (state_reg == ST_RINSE) ||
                        (state_reg == ST_SPIN);

`ifdef WM_PAUSE_EN
   assign hold = pause & timed_stage;
`else
   logic pause_unused;
   assign pause_unused = pause;
   assign hold         = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= ST_IDLE;
         count_reg        <= '0;
         pass_reg         <= '0;
         drained_seen_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         count_reg        <= count_next;
         pass_reg         <= pass_next;
         drained_seen_reg <= drained_seen_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pass_next  = pass_reg;
      case (state_reg)
         ST_IDLE: begin
            pass_next = '0;
            if (start && door_close) state_next = ST_FILL;
         end
         ST_FILL: begin
            if (filled)                      state_next = (pass_reg == 3'd0) ? ST_WAIT_SOAP : ST_RINSE;
            else if (count_reg == FILL_LAST) state_next = ST_FAULT;
         end
         ST_WAIT_SOAP: if (detergent_added) state_next = ST_WASH;
         ST_WASH:  if (!hold && count_reg == WASH_LAST)  state_next = ST_DRAIN;
         ST_RINSE: if (!hold && count_reg == RINSE_LAST) state_next = ST_DRAIN;
         ST_SPIN:  if (!hold && count_reg == SPIN_LAST)  state_next = ST_DONE;
         ST_DRAIN: begin
            if (drained) begin
               if (pass_reg < PASSES) begin
                  pass_next  = pass_reg + 3'd1;
                  state_next = ST_FILL;
               end else begin
                  state_next = ST_SPIN;
               end
            end
         end
         ST_DONE:  if (!start)          state_next = ST_IDLE;
         ST_ABORT: if (drained)         state_next = ST_IDLE;
         ST_FAULT: if (abort && drained) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      // An opened door outranks a cancel, which outranks normal sequencing.
      if (locked_run) begin
         if (!door_close) begin
            state_next = ST_FAULT;
            pass_next  = pass_reg;
         end else if (abort) begin
            state_next = ST_ABORT;
            pass_next  = pass_reg;
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      if (state_next != state_reg) count_next = '0;
      else if (!hold && count_reg != CNT_MAX) count_next = count_reg + 1'b1;
      drained_seen_next = (state_reg == ST_FAULT) ? (drained_seen_reg | drained) : 1'b0;
   end

   always_comb begin
      door_lock      = 1'b0;
      motor_on       = 1'b0;
      fill_valve_on  = 1'b0;
      drain_valve_on = 1'b0;
      soap_wash      = 1'b0;
      water_wash     = 1'b0;
      done           = 1'b0;
      fault          = 1'b0;
      case (state_reg)
         ST_FILL:      begin door_lock = 1'b1; fill_valve_on = 1'b1; end
         ST_WAIT_SOAP: door_lock = 1'b1;
         ST_WASH:      begin door_lock = 1'b1; motor_on = ~hold; soap_wash = 1'b1; end
         ST_RINSE:     begin door_lock = 1'b1; motor_on = ~hold; water_wash = 1'b1; end
         ST_DRAIN:     begin door_lock = 1'b1; drain_valve_on = 1'b1; end
         ST_SPIN:      begin door_lock = 1'b1; motor_on = ~hold; drain_valve_on = 1'b1; end
         ST_DONE:      done = 1'b1;
         ST_ABORT:     begin door_lock = 1'b1; drain_valve_on = 1'b1; end
         ST_FAULT:     begin fault = 1'b1; drain_valve_on = 1'b1; door_lock = ~drained_seen_reg; end
         default:      ;
      endcase
   end

   assign state = state_reg;

endmodule

// File: tb/tb_wm_cycle_scheduler.sv
// Directed bench for wm_cycle_scheduler (default build, pause feature disabled).
module tb_wm_cycle_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, door_close = 1'b0, filled = 1'b0, detergent_added = 1'b0;
   logic       drained = 1'b0, abort = 1'b0, pause = 1'b0;
   logic       door_lock, motor_on, fill_valve_on, drain_valve_on;
   logic       soap_wash, water_wash, done, fault;
   logic [3:0] state;
   logic [7:0] outs;
   int         total = 0;
   int         bad = 0;
   int         n;
   logic       done_seen;

   always #5 clk = ~clk;

   assign outs = {door_lock, motor_on, fill_valve_on, drain_valve_on,
                  soap_wash, water_wash, done, fault};

   wm_cycle_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .door_close(door_close),
      .filled(filled), .detergent_added(detergent_added), .drained(drained),
      .abort(abort), .pause(pause), .door_lock(door_lock), .motor_on(motor_on),
      .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
      .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
      .fault(fault), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input logic [3:0] st, output int cnt);
      cnt = 0;
      while (state == st && cnt < 500) begin
         cnt++;
         step();
      end
   endtask

   task automatic wait_for(input string tag, input logic [3:0] st, input int max);
      int k;
      k = 0;
      while (state != st && k < max) begin
         k++;
         step();
      end
      chk(tag, state, st);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_state", state, 4'd0);
      chk("rst_outs", outs, 8'h00);
      step();
      reset = 1'b1;
      step();
      chk("idle_state", state, 4'd0);

      // 1. Full programme
      start = 1'b1; door_close = 1'b1;
      step();
      chk("t1_fill", state, 4'd1);
      chk("t1_fill_outs", outs, 8'b1010_0000);
      filled = 1'b1;
      step();
      chk("t1_wait_soap", state, 4'd2);
      filled = 1'b0; detergent_added = 1'b1;
      step();
      chk("t1_wash", state, 4'd3);
      chk("t1_wash_outs", outs, 8'b1100_1000);
      detergent_added = 1'b0; filled = 1'b1; drained = 1'b1;
      measure(4'd3, n);
      chk("t1_wash_len", n, 20);
      chk("t1_drain0", state, 4'd4);
      chk("t1_drain_outs", outs, 8'b1001_0000);
      step();
      chk("t1_refill1", state, 4'd1);
      step();
      chk("t1_rinse1", state, 4'd5);
      chk("t1_rinse_outs", outs, 8'b1100_0100);
      measure(4'd5, n);
      chk("t1_rinse1_len", n, 10);
      chk("t1_drain1", state, 4'd4);
      step();
      chk("t1_refill2", state, 4'd1);
      step();
      measure(4'd5, n);
      chk("t1_rinse2_len", n, 10);
      chk("t1_drain2", state, 4'd4);
      step();
      chk("t1_spin", state, 4'd6);
      chk("t1_spin_outs", outs, 8'b1101_0000);
      measure(4'd6, n);
      chk("t1_spin_len", n, 15);
      chk("t1_done", state, 4'd7);
      chk("t1_done_outs", outs, 8'b0000_0010);
      filled = 1'b0; drained = 1'b0;
      step();
      chk("t1_done_hold", state, 4'd7);
      start = 1'b0;
      step();
      chk("t1_idle", state, 4'd0);

      // 2. start without door closed is ignored
      start = 1'b1; door_close = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_state", state, 4'd0);
         chk("t2_outs", outs, 8'h00);
      end

      // 3. Fill timeout fault
      door_close = 1'b1;
      step();
      chk("t3_fill", state, 4'd1);
      n = 0;
      while (state == 4'd1 && n < 200) begin
         step();
         n++;
      end
      chk("t3_fault_delay", n, 50);
      chk("t3_fault_state", state, 4'd9);
      chk("t3_fault_outs", outs, 8'b1001_0001);
      start = 1'b0; drained = 1'b1;
      step();
      chk("t3_unlock", door_lock, 1'b0);
      chk("t3_still_fault", state, 4'd9);
      abort = 1'b1;
      step();
      chk("t3_idle", state, 4'd0);
      abort = 1'b0; drained = 1'b0;

      // 4. Abort during WASH
      start = 1'b1; filled = 1'b1; detergent_added = 1'b1;
      step();
      step();
      step();
      chk("t4_wash", state, 4'd3);
      filled = 1'b0; detergent_added = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("t4_wash_c7", state, 4'd3);
      abort = 1'b1;
      step();
      chk("t4_abort", state, 4'd8);
      chk("t4_abort_outs", outs, 8'b1001_0000);
      start = 1'b0;
      step();
      chk("t4_abort_hold", state, 4'd8);
      drained = 1'b1;
      step();
      chk("t4_idle", state, 4'd0);
      chk("t4_no_done", done, 1'b0);
      abort = 1'b0; drained = 1'b0;

      // 5. Asynchronous reset mid-SPIN
      start = 1'b1; filled = 1'b1; detergent_added = 1'b1; drained = 1'b1;
      wait_for("t5_reach_spin", 4'd6, 200);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_outs", outs, 8'h00);
      chk("t5_async_state", state, 4'd0);
      start = 1'b0; filled = 1'b0; detergent_added = 1'b0; drained = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("t5_after_release", state, 4'd0);

      // 6. pause is ignored without the pause option
      start = 1'b1; filled = 1'b1; detergent_added = 1'b1;
      step();
      step();
      step();
      chk("t6_wash", state, 4'd3);
      start = 1'b0; filled = 1'b0; detergent_added = 1'b0;
      n = 0;
      done_seen = 1'b0;
      while (state == 4'd3 && n < 500) begin
         pause = (n >= 10 && n < 15);
         if (n == 12) begin
            chk("t6_motor_pause", motor_on, 1'b1);
            done_seen = 1'b1;
         end
         n++;
         step();
      end
      pause = 1'b0;
      chk("t6_pause_checked", done_seen, 1'b1);
      chk("t6_wash_len", n, 20);
      chk("t6_drain", state, 4'd4);
      abort = 1'b1; drained = 1'b1;
      step();
      step();
      chk("t6_idle", state, 4'd0);
      abort = 1'b0; drained = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
